// File: rtl/shift_seq_ctrl_pkg.sv
// shift_seq_ctrl_pkg: shared state type and default sizing for the shift sequencer
package shift_seq_ctrl_pkg;
    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;
    localparam int DEF_WIDTH = 8;
    localparam int DEF_DIV = 4;
endpackage

// File: rtl/shift_seq_ctrl_shift_cell.sv
// shift_cell: one register bit, parallel load when move=1, serial shift when move=0
// clk_i, rst_i: clock and synchronous active-high reset
// en: clock enable; move: 1 = take parallel_in, 0 = take serial_in; q: stored bit
module shift_cell (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en,
    input  logic move,
    input  logic parallel_in,
    input  logic serial_in,
    output logic q
);
    always_ff @(posedge clk_i)
        if (rst_i) q <= 1'b0;
        else if (en) q <= (move & parallel_in) | (~move & serial_in);
endmodule

// File: rtl/shift_seq_ctrl.sv
// shift_seq_ctrl: load a word, shift it out MSB-first while shifting serial_i in, one bit per DIV cycles
// clk_i, rst_i: clock and synchronous active-high reset
// start_i, abort_i: request / cancel a transfer; data_i: word to send
// serial_i / serial_o: serial in (to LSB) / out (from MSB); data_o: last received word
// move_o: cell select (1 = load); busy_o: LOAD or SHIFT; done_o: one-cycle completion pulse
module shift_seq_ctrl
    import shift_seq_ctrl_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DIV = DEF_DIV
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             serial_i,
    output logic             serial_o,
    output logic [WIDTH-1:0] data_o,
    output logic             move_o,
    output logic             busy_o,
    output logic             done_o
);
    localparam int DW = DIV > 1 ? $clog2(DIV) : 1;
    localparam int BW = $clog2(WIDTH + 1);
    localparam logic [DW-1:0] DMAX = DW'(DIV - 1);
    localparam logic [BW-1:0] BLAST = BW'(WIDTH - 1);

    state_t st, nxt;
    logic [WIDTH-1:0] lat, q, chain;
    logic [DW-1:0] div;
    logic [BW-1:0] bitc;
    logic wrap, en;

    assign wrap = st == SHIFT && div == DMAX;
    assign move_o = st == LOAD;
    assign en = move_o || wrap;
    assign busy_o = st == LOAD || st == SHIFT;
    assign done_o = st == DONE;
    assign serial_o = q[WIDTH-1];
    // each cell shifts in its lower neighbour; cell 0 takes the serial input
    assign chain = {q[WIDTH-2:0], serial_i};

    always_comb begin
        nxt = st;
        case (st)
            IDLE:    nxt = start_i && !abort_i ? LOAD : IDLE;
            LOAD:    nxt = abort_i ? IDLE : SHIFT;
            SHIFT:   nxt = abort_i ? IDLE : wrap && bitc == BLAST ? DONE : SHIFT;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            st <= IDLE;
            lat <= '0;
            div <= '0;
            bitc <= '0;
            data_o <= '0;
        end else begin
            st <= nxt;
            if (st == IDLE && start_i && !abort_i) lat <= data_i;
            if (st == LOAD) begin
                div <= '0;
                bitc <= '0;
            end else if (st == SHIFT) begin
                div <= wrap ? '0 : div + 1'b1;
                if (wrap) bitc <= bitc + 1'b1;
            end
            if (st == DONE) data_o <= q;
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        shift_cell u_cell (
            .clk_i      (clk_i),
            .rst_i      (rst_i),
            .en         (en),
            .move       (move_o),
            .parallel_in(lat[i]),
            .serial_in  (chain[i]),
            .q          (q[i])
        );
    end
endmodule

// File: tb/tb_shift_seq_ctrl.sv
// tb_shift_seq_ctrl: randomized scoreboard bench for shift_seq_ctrl at DIV=4 and DIV=1
module tb_shift_seq_ctrl;
    localparam int W = 8;
    localparam int NC = 16384;

    logic clk = 0;
    int cyc = 0;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int g, input int c, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s dut%0d cycle %0d: got %0h expected %0h", nm, g, c, a, e);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_cfg
        localparam int D = g == 0 ? 4 : 1;
        localparam int N = 2 + W * D;

        logic rst = 1, start = 0, abort = 0, sin = 0;
        logic [W-1:0] dat = '0;
        logic so, mv, bz, dn;
        logic [W-1:0] dq;
        bit eb[NC], em[NC], ed[NC], ev[NC], es[NC];
        logic [W-1:0] q[$];
        logic [W-1:0] cur = '0;
        bit act = 0, prst = 0, fin = 0, fd = 0;

        shift_seq_ctrl #(.WIDTH(W), .DIV(D)) dut (
            .clk_i   (clk),
            .rst_i   (rst),
            .start_i (start),
            .abort_i (abort),
            .data_i  (dat),
            .serial_i(sin),
            .serial_o(so),
            .data_o  (dq),
            .move_o  (mv),
            .busy_o  (bz),
            .done_o  (dn)
        );

        task automatic step();
            @(posedge clk);
            #1;
        endtask

        // One transfer accepted in the current cycle. ab / rs: cycle offset of abort / reset (-1 = none).
        // Expected busy/move/done/serial per absolute cycle go into the maps; a completed transfer
        // queues the received word, which equals the serial word driven MSB-first one bit per period.
        task automatic xfer(input logic [W-1:0] d, input logic [W-1:0] s, input int ab, input int rs, input bit hold);
            int c0, last;
            c0 = cyc;
            last = (ab >= 1 && ab < N) ? ab : (rs >= 1 && rs < N) ? rs : N;
            for (int o = 1; o <= last && o < N; o++) eb[c0+o] = 1;
            em[c0+1] = 1;
            if (last == N) begin
                ed[c0+N] = 1;
                q.push_back(s);
            end
            for (int o = 2; o <= last && o < N; o++) begin
                ev[c0+o] = 1;
                es[c0+o] = d[W-1-(o-2)/D];
            end
            for (int o = 0; o <= last; o++) begin
                start = o == 0 || hold ? 1'b1 : 1'($urandom_range(1));
                dat = o == 0 ? d : W'($urandom);
                abort = o == ab;
                rst = o == rs;
                sin = o >= 2 && o < N ? s[W-1-(o-2)/D] : 1'($urandom_range(1));
                step();
            end
            start = hold;
            abort = 0;
            rst = 0;
        endtask

        initial begin
            int k, ab, rs, gap;
            bit h;
            rst = 1;
            step();
            act = 1;
            step();
            step();
            rst = 0;
            if (D == 4) xfer(8'hA5, 8'h3C, -1, -1, 0);
            else xfer(8'hFF, 8'h00, -1, -1, 0);
            xfer(8'hA5, W'($urandom), D == 4 ? 10 : 5, -1, 0);
            xfer(8'h5A, W'($urandom), -1, D == 4 ? 20 : 5, 0);
            xfer(8'hC3, 8'h96, -1, -1, 1);
            xfer(8'h81, 8'h7E, -1, -1, 1);
            xfer(8'h3C, 8'hE1, -1, -1, 0);
            start = 1;
            abort = 1;
            repeat (4) step();
            start = 0;
            abort = 0;
            for (int i = 0; i < 16; i++) begin
                k = $urandom_range(5);
                ab = k == 3 ? int'($urandom_range(N - 1, 1)) : k == 4 ? N : -1;
                rs = k == 5 ? int'($urandom_range(N - 1, 1)) : -1;
                h = k < 2 && i < 15;
                xfer(W'($urandom), W'($urandom), ab, rs, h);
                if (!h) begin
                    gap = $urandom_range(3);
                    for (int j = 0; j < gap; j++) begin
                        start = 1'($urandom_range(1));
                        abort = start;
                        step();
                    end
                    start = 0;
                    abort = 0;
                end
            end
            step();
            step();
            fin = 1;
        end

        always @(negedge clk) if (act && cyc < NC) begin
            chk("busy", g, cyc, 32'(bz), 32'(eb[cyc]));
            chk("move", g, cyc, 32'(mv), 32'(em[cyc]));
            chk("done", g, cyc, 32'(dn), 32'(ed[cyc]));
            if (ev[cyc]) chk("serial", g, cyc, 32'(so), 32'(es[cyc]));
            if (prst) chk("serial_after_reset", g, cyc, 32'(so), 32'(0));
            chk("data", g, cyc, 32'(dq), 32'(cur));
            if (dn && q.size() != 0) cur = q.pop_front();
            if (rst) cur = '0;
            prst = rst;
            if (fin && !fd) begin
                chk("pending_transfers", g, cyc, 32'(q.size()), 32'(0));
                fd = 1;
            end
        end
    end

    initial begin
        while (!(g_cfg[0].fd && g_cfg[1].fd)) begin
            @(posedge clk);
            if (cyc > 60000) begin
                $display("FAIL timeout at cycle %0d", cyc);
                $fatal(1, "timeout");
            end
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
